// File: rtl/digit_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// digit_sweep_ctrl
//
// Purpose:
//   Self-running sequencer that sits in front of the digit-processing datapath
//   and drives it through one full exhaustive sweep.
//
//   While running, it does two things at once:
//   - It streams the captured 32-bit operand word into X, one hex digit per
//     clock. Leading-zero digits are skipped and the stream recirculates.
//   - It steps the address A through 0..31 and the control pair {S,I} through
//     00, 01, 10, 11. Each {A,S,I} combination is held for HOLD clocks.
//
//   A full sweep takes 128*HOLD RUN edges. It ends with a one-cycle done pulse.
//
// Parameters:
//   HOLD     - clocks each {A,S,I} combination is held (legal range 2..256).
//
// Ports:
//   Clk      in   1   system clock, rising-edge active
//   Rst_n    in   1   asynchronous active-low reset
//   start    in   1   begin a sweep; sampled only in IDLE
//   abort    in   1   synchronous cancel back to IDLE, outputs frozen
//   pause    in   1   (only when DSC_PAUSE_EN is defined) freeze RUN progress
//   word_in  in  32   operand word, captured on an accepted start
//   A        out  5   datapath address (registered)
//   S        out  1   datapath select (registered)
//   I        out  1   datapath input bit (registered)
//   X        out 32   digit-accumulating operand (registered)
//   busy     out  1   high while in RUN
//   done     out  1   one-cycle pulse at sweep completion
//
// Configuration:
//   DSC_PAUSE_EN - when defined, adds the pause input. While pause is high
//                  in RUN, all sweep and stream state freezes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module digit_sweep_ctrl #(
  parameter int HOLD = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  input  logic        abort,
`ifdef DSC_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [31:0] word_in,
  output logic [4:0]  A,
  output logic        S,
  output logic        I,
  output logic [31:0] X,
  output logic        busy,
  output logic        done
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [31:0]    word_reg;
  logic [31:0]    rem;
  logic [HW-1:0]  hold_cnt;
  logic           frozen;

  // A paused RUN cycle advances nothing. Without the pause feature,
  // RUN moves forward on every edge.
`ifdef DSC_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  // Single sequencer process.
  // abort is checked first so that it outranks both start and completion.
  // The last sweep step does not advance A/S/I. That leaves the final
  // combination (31,1,1) on the outputs through DONE and IDLE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      A        <= 5'd0;
      S        <= 1'b0;
      I        <= 1'b0;
      X        <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_reg <= 32'd0;
      rem      <= 32'd0;
      hold_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_reg <= word_in;
            rem      <= word_in;
            X        <= 32'd0;
            A        <= 5'd0;
            S        <= 1'b0;
            I        <= 1'b0;
            hold_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (!frozen) begin
            X <= {X[27:0], rem[3:0]};
            // Reload when only the last significant digit remains.
            // This skips the word's leading zeros.
            if (rem[31:4] == 28'd0) begin
              rem <= word_reg;
            end else begin
              rem <= {4'h0, rem[31:4]};
            end

            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if ((A == 5'd31) && S && I) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                {S, I} <= {S, I} + 2'd1;
                if (S && I) begin
                  A <= A + 5'd1;
                end
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_sweep_ctrl
//
// Purpose:
//   Directed self-checking bench for digit_sweep_ctrl with HOLD=8.
//
//   It covers:
//   - reset values
//   - the digit stream with a skipped leading zero
//   - sweep ordering and completion timing
//   - an all-zero word
//   - a start that arrives during RUN
//   - abort behaviour, including abort together with start in IDLE
//   - reset arriving mid-sweep
//   - pause, when DSC_PAUSE_EN is defined
//
//   The variable n counts DUT edges since the accepted start.
//   Outputs are sampled 1ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_digit_sweep_ctrl;

  logic        Clk;
  logic        Rst_n;
  logic        start;
  logic        abort;
`ifdef DSC_PAUSE_EN
  logic        pause;
`endif
  logic [31:0] word_in;
  logic [4:0]  A;
  logic        S;
  logic        I;
  logic [31:0] X;
  logic        busy;
  logic        done;

  int checks;
  int errors;
  int done_count;
  int n;

  digit_sweep_ctrl #(.HOLD(8)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .start   (start),
    .abort   (abort),
`ifdef DSC_PAUSE_EN
    .pause   (pause),
`endif
    .word_in (word_in),
    .A       (A),
    .S       (S),
    .I       (I),
    .X       (X),
    .busy    (busy),
    .done    (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count done pulses on the falling edge, away from the update edge.
  initial done_count = 0;
  always @(negedge Clk) begin
    if (done === 1'b1) done_count++;
  end

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] asi();
    return {25'd0, A, S, I};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic advance(input int count);
    repeat (count) begin
      @(posedge Clk);
      #1;
      n++;
    end
  endtask

  // Present a word with start for one edge. On return, n=0 is the
  // accepting edge.
  task automatic applyStimulus(input logic [31:0] word);
    word_in = word;
    start   = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    n     = 0;
  endtask

  logic [31:0] x_table [1:9];
  logic        zero_bad;

  initial begin
    checks  = 0;
    errors  = 0;
    n       = 0;
    Rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    word_in = 32'd0;
`ifdef DSC_PAUSE_EN
    pause   = 1'b0;
`endif
    x_table[1] = 32'h00000007;
    x_table[2] = 32'h00000077;
    x_table[3] = 32'h00000771;
    x_table[4] = 32'h00007716;
    x_table[5] = 32'h00077160;
    x_table[6] = 32'h00771608;
    x_table[7] = 32'h07716081;
    x_table[8] = 32'h77160817;
    x_table[9] = 32'h71608177;

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_asi",  asi(), 32'h0);
    checkOutput("rst_x",    X, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    Rst_n = 1'b1;
    advance(1);

    // Digit stream and sweep order
    applyStimulus(32'h01806177);
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_x",    X, 32'h0);
    checkOutput("start_asi",  asi(), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      advance(1);
      checkOutput($sformatf("stream_x%0d", i), X, x_table[i]);
      if (i == 7) checkOutput("asi_n7", asi(), 32'h00);
      if (i == 8) checkOutput("asi_n8", asi(), 32'h01);
    end
    advance(16 - n);
    checkOutput("asi_n16", asi(), 32'h02);
    advance(24 - n);
    checkOutput("asi_n24", asi(), 32'h03);
    advance(31 - n);
    checkOutput("asi_n31", asi(), 32'h03);
    advance(1);
    checkOutput("asi_n32", asi(), 32'h04);

    // A start during RUN must be ignored
    advance(40 - n);
    start   = 1'b1;
    word_in = 32'h0;
    advance(1);
    start = 1'b0;
    checkOutput("run_start_asi",  asi(), 32'h05);
    checkOutput("run_start_busy", 32'(busy), 32'd1);

    // Completion
    advance(1023 - n);
    checkOutput("n1023_busy", 32'(busy), 32'd1);
    checkOutput("n1023_done", 32'(done), 32'd0);
    checkOutput("n1023_asi",  asi(), 32'h7F);
    advance(1);
    checkOutput("n1024_done", 32'(done), 32'd1);
    checkOutput("n1024_busy", 32'(busy), 32'd0);
    checkOutput("n1024_asi",  asi(), 32'h7F);
    advance(1);
    checkOutput("n1025_done", 32'(done), 32'd0);
    checkOutput("n1025_asi",  asi(), 32'h7F);
    checkOutput("done_once",  32'(done_count), 32'd1);

    // Zero word
    applyStimulus(32'h0);
    zero_bad = 1'b0;
    for (int i = 1; i <= 1023; i++) begin
      advance(1);
      if (X !== 32'h0) zero_bad = 1'b1;
    end
    checkOutput("zero_x_stream", 32'(zero_bad), 32'd0);
    checkOutput("zero_n1023_done", 32'(done), 32'd0);
    advance(1);
    checkOutput("zero_n1024_done", 32'(done), 32'd1);
    advance(1);
    checkOutput("zero_done_total", 32'(done_count), 32'd2);

    // Abort at A=5, {S,I}=10
    applyStimulus(32'h12345678);
    advance(176);
    checkOutput("pre_abort_asi", asi(), 32'h16);
    checkOutput("pre_abort_x",   X, 32'h87654321);
    abort = 1'b1;
    advance(1);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_asi",  asi(), 32'h16);
    checkOutput("abort_x",    X, 32'h87654321);
    advance(5);
    checkOutput("abort_hold_asi", asi(), 32'h16);
    checkOutput("abort_hold_x",   X, 32'h87654321);
    checkOutput("abort_no_done",  32'(done_count), 32'd2);

    // Abort and start together in IDLE
    abort   = 1'b1;
    start   = 1'b1;
    word_in = 32'hFFFFFFFF;
    advance(1);
    abort = 1'b0;
    start = 1'b0;
    advance(1);
    checkOutput("abort_start_busy", 32'(busy), 32'd0);
    checkOutput("abort_start_asi",  asi(), 32'h16);
    checkOutput("abort_start_x",    X, 32'h87654321);

    // Reset mid-sweep
    applyStimulus(32'h01806177);
    advance(300);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst_asi",  asi(), 32'h0);
    checkOutput("midrst_x",    X, 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    advance(3);
    Rst_n = 1'b1;
    advance(1100);
    checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
    checkOutput("midrst_no_done",   32'(done_count), 32'd2);

`ifdef DSC_PAUSE_EN
    // Pause for 10 cycles at A=2 delays completion by exactly 10 edges
    applyStimulus(32'h12345678);
    advance(64);
    checkOutput("pause_pre_asi", asi(), 32'h08);
    pause    = 1'b1;
    zero_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      advance(1);
      if (asi() !== 32'h08 || X !== 32'h87654321 || busy !== 1'b1) zero_bad = 1'b1;
    end
    pause = 1'b0;
    checkOutput("pause_frozen", 32'(zero_bad), 32'd0);
    advance(1033 - n);
    checkOutput("pause_n1033_done", 32'(done), 32'd0);
    advance(1);
    checkOutput("pause_n1034_done", 32'(done), 32'd1);
    advance(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
